// File: rtl/game_session_ctrl.sv
// Credit-based game session sequencer: counts paid credits, arms on master-code load,
// starts a game on a synchronized start-button edge and holds in OVER before re-arming.
module game_session_ctrl #(
    parameter int MAX_CREDITS = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       drop,
    input  logic       startButton,
    input  logic       masterLoaded,
    input  logic       gameOver,
    output logic       startGameNow,
    output logic       gamePlaying,
    output logic       ready,
    output logic [3:0] NumGames,
    output logic       creditFull
);

    // state | meaning
    // IDLE  | no credit or no master code; cannot start
    // ARMED | credit and master code present; waiting for a start edge
    // PLAY  | game running until gameOver
    // OVER  | post-game hold for HOLD_CYCLES cycles
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0] LP_MAX       = 4'(MAX_CREDITS);
    localparam logic [7:0] LP_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_num_games;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync2_d;
    logic [2:0] r_vld;
    logic       r_start_edge;
    logic       w_start;

    // r_vld keeps reset-forced zeros in the sync chain from looking like a released button,
    // so a button already held at reset release never produces an edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync2_d    <= 1'b0;
            r_vld        <= 3'b000;
            r_start_edge <= 1'b0;
        end else begin
            r_sync1      <= startButton;
            r_sync2      <= r_sync1;
            r_sync2_d    <= r_sync2;
            r_vld        <= {r_vld[1:0], 1'b1};
            r_start_edge <= r_sync2 & ~r_sync2_d & r_vld[2];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_num_games != 4'd0 && masterLoaded) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                if (r_num_games == 4'd0 || !masterLoaded) begin
                    w_next_state = IDLE;
                end else if (r_start_edge) begin
                    w_next_state = PLAY;
                    w_start      = 1'b1;
                end
            end
            PLAY: begin
                if (gameOver) begin
                    w_next_state = OVER;
                end
            end
            OVER: begin
                if (r_hold_cnt == 8'd0) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state == PLAY && gameOver) begin
            r_hold_cnt <= LP_HOLD_LOAD;
        end else if (r_state == OVER && r_hold_cnt != 8'd0) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
        end
    end

    // A drop coinciding with a start cancels the start's decrement unless the counter is full.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_num_games <= 4'd0;
        end else begin
            case ({drop, w_start})
                2'b01: r_num_games <= r_num_games - 4'd1;
                2'b10: if (r_num_games < LP_MAX) r_num_games <= r_num_games + 4'd1;
                2'b11: if (r_num_games >= LP_MAX) r_num_games <= r_num_games - 4'd1;
                default: r_num_games <= r_num_games;
            endcase
        end
    end

    assign startGameNow = w_start;
    assign gamePlaying  = (r_state == PLAY);
    assign ready        = (r_state == ARMED);
    assign NumGames     = r_num_games;
    assign creditFull   = (r_num_games == LP_MAX);

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed-vector bench for game_session_ctrl with default MAX_CREDITS=7, HOLD_CYCLES=4.
module tb_game_session_ctrl;

    logic       CLOCK_50;
    logic       reset;
    logic       drop;
    logic       startButton;
    logic       masterLoaded;
    logic       gameOver;
    logic       startGameNow;
    logic       gamePlaying;
    logic       ready;
    logic [3:0] NumGames;
    logic       creditFull;

    int vectors;
    int miscompares;

    game_session_ctrl #(.MAX_CREDITS(7), .HOLD_CYCLES(4)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .drop         (drop),
        .startButton  (startButton),
        .masterLoaded (masterLoaded),
        .gameOver     (gameOver),
        .startGameNow (startGameNow),
        .gamePlaying  (gamePlaying),
        .ready        (ready),
        .NumGames     (NumGames),
        .creditFull   (creditFull)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic sgn, input logic gp,
                              input logic rdy, input logic [3:0] ng, input logic cf);
        check({tag, ".startGameNow"}, {7'd0, startGameNow}, {7'd0, sgn});
        check({tag, ".gamePlaying"},  {7'd0, gamePlaying},  {7'd0, gp});
        check({tag, ".ready"},        {7'd0, ready},        {7'd0, rdy});
        check({tag, ".NumGames"},     {4'd0, NumGames},     {4'd0, ng});
        check({tag, ".creditFull"},   {7'd0, creditFull},   {7'd0, cf});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        drop         = 1'b0;
        startButton  = 1'b0;
        masterLoaded = 1'b0;
        gameOver     = 1'b0;
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        masterLoaded = 1'b1;
        tick();

        // credit then start
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check_outs("credit1", 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        tick();
        check_outs("armed", 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check_outs("credit2", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        startButton = 1'b1;
        tick();
        check_outs("sync_e1", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        tick();
        check_outs("sync_e2", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        tick();
        check_outs("start_pulse", 1'b1, 1'b0, 1'b1, 4'd2, 1'b0);
        tick();
        check_outs("playing", 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);

        // game end with button held, one credit bought during OVER
        gameOver = 1'b1;
        tick();
        gameOver = 1'b0;
        check_outs("over1", 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check_outs("over2_drop", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        tick();
        check_outs("over3", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        tick();
        check_outs("over4", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        tick();
        check_outs("idle_after_over", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        tick();
        check_outs("rearmed", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs("held_no_autostart", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        end

        // drop coincident with start at 3 credits
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check_outs("credit3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        startButton = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        startButton = 1'b1;
        tick();
        tick();
        tick();
        check_outs("start2_pulse", 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check_outs("start_and_drop", 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);

        // masterLoaded falls in PLAY: no effect; extra credits during PLAY
        masterLoaded = 1'b0;
        tick();
        check_outs("ml_low_play", 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        masterLoaded = 1'b1;
        drop = 1'b1;
        tick();
        tick();
        drop = 1'b0;
        check_outs("play_credit5", 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);

        // reset mid-game with button still held
        reset = 1'b1;
        tick();
        check_outs("reset_mid_game", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;

        // saturation; held button from before reset must never start a game
        for (int i = 1; i <= 9; i++) begin
            drop = 1'b1;
            tick();
            drop = 1'b0;
            check({"sat_sgn"}, {7'd0, startGameNow}, 8'd0);
            if (i == 6) check_outs("sat6", 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
            if (i == 7) check_outs("sat7", 1'b0, 1'b0, 1'b1, 4'd7, 1'b1);
        end
        check_outs("sat9", 1'b0, 1'b0, 1'b1, 4'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs("held_through_reset", 1'b0, 1'b0, 1'b1, 4'd7, 1'b1);
        end

        // no master code
        reset = 1'b1;
        tick();
        reset = 1'b0;
        masterLoaded = 1'b0;
        drop = 1'b1;
        tick();
        tick();
        drop = 1'b0;
        check_outs("nomaster_credit", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        startButton = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        startButton = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_outs("nomaster_press", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        end
        masterLoaded = 1'b1;
        tick();
        check_outs("master_up", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        tick();
        check_outs("master_up_hold", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        masterLoaded = 1'b0;
        tick();
        check_outs("master_drop_armed", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
